pb_write_arb: RTL and testbench
===============================

# pb_write_arb

Round-robin arbiter and output register that shares the single pixel-buffer write port between the scene-intersection result streams. Requesters are the shader-result stream, the scene-miss (background) stream and any further colour producers. It replaces the fixed two-way alternating select in front of the pixel buffer with the following:
- work-conserving, fair arbitration;
- a registered write stage that honours `pb_full`;
- per-requester valid/stall handshakes.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = shader, 1 = scene miss, 2 = spare.
- CNT_W, 16, width of each grant counter (stats build only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i presents an entry.
- req_data  in  NUM_REQ x pixel_buffer_entry_t  {pixelID, color} per requester.
- req_stall  out  NUM_REQ  requester i must hold its entry.
- pb_full  in  1  pixel buffer cannot accept a write this cycle.
- pb_data  out  pixel_buffer_entry_t  write entry.
- pb_we  out  1  write strobe.
- arb_idle  out  1  output register empty and no req_valid asserted.
- grant_cnt  out  NUM_REQ x CNT_W  accepted-entry count per requester (only when PB_ARB_STATS_EN).

## Operation
- Handshake: an entry transfers from requester i in a cycle where `req_valid[i] && !req_stall[i]`. A requester holds valid and data stable while it is stalled.
- Output register: `out_valid` and `out_data`. The `load` signal is `!out_valid || !pb_full`.
- `pb_we = out_valid && !pb_full`; `pb_data = out_data`. The data is driven whenever `out_valid` is set.
- Grant: when `load` is true and any req_valid is set, exactly one requester is granted. The grant goes to the first valid index found scanning from `(last+1) mod NUM_REQ` upward with wrap.
- On a grant, `out_data` takes the granted entry, `out_valid` is set to 1, and `last` takes the granted index.
- When `load` is true and no requester is valid, `out_valid` is cleared to 0.
- `req_stall[i] = !(load && grant[i])`. This is combinational from req_valid, `last`, out_valid and pb_full. No stall path depends on req_data.
- When `load` is false, every requester is stalled and `last` holds.
- Simultaneous write and load: while `out_valid && !pb_full`, the current entry is written and a new entry loads in the same cycle. This sustains full throughput.
- Only one active requester: that requester is granted every cycle, since arbitration is work-conserving.
- Reset state: `out_valid=0`, `pb_we=0`, `pb_data=0`, `last=NUM_REQ-1` (so requester 0 has first priority), `req_stall` all 1 while in reset, `arb_idle=1`, `grant_cnt=0`.
- Reset asserted mid-operation: the entry held in the output register is discarded and nothing is written. Upstream FIFOs are reset by the same signal.

## Timing
- Latency: the transfer in cycle t produces `pb_we` in cycle t+1 if `pb_full` is low in t+1. Otherwise the write holds until the first cycle with `pb_full` low.
- Throughput: one write per cycle while `pb_full` stays low.
- Fairness: among continuously valid requesters, each is granted at least once in any NUM_REQ consecutive grants.
- `pb_full` takes effect in the same cycle: `pb_we` and all `req_stall` respond combinationally.

## Configuration
- PB_ARB_STATS_EN defined: NUM_REQ counters are built. Each counter increments by 1 on every accepted transfer from its requester, wraps modulo 2^CNT_W, and is cleared by reset.
- PB_ARB_STATS_EN undefined: no counters are built and the `grant_cnt` port is absent.
- Arbitration behaviour is identical in both builds.

## Structure
- Shared package: `pixel_buffer_entry_t` (existing), plus new `localparam PB_REQ_SHADER=0`, `PB_REQ_MISS=1`.
- Sub-module `rr_pick`:
  - parameter N;
  - inputs `req[N]` and `last` index;
  - outputs one-hot `grant[N]` and `grant_idx`.
  - It is purely combinational, and reusable by the traversal-FIFO arbiters.
- Registers: use the existing asynchronous-reset flop `ff_ar`, driven with the active-low `rst`.

## Test plan
- Reset then idle: `rst` low for 3 cycles → `pb_we=0`, `req_stall` all 1 during reset, `arb_idle=1`. After release with no requests, `req_stall` all 1 and `arb_idle=1`.
- Single requester streaming: `req_valid[1]=1` with pixelIDs 0..9 and `pb_full=0` → 10 consecutive `pb_we` pulses with pixelIDs 0..9, the first write one cycle after the first transfer, and `req_stall[1]=0` throughout.
- Full contention: all 3 valid continuously for 9 grants → grant order 0,1,2,0,1,2,0,1,2 and every write in order.
- Backpressure: `pb_full=1` for 4 cycles with out_valid set → `pb_we=0`, `pb_data` stable, all `req_stall=1`. When `pb_full` drops, the held entry is written and the next grant follows the round-robin order.
- Simultaneous write and load: requesters 0 and 2 valid with `last=0` and `out_valid=1` → requester 2 is granted in the same cycle as the write, with no bubble.
- Stats build (PB_ARB_STATS_EN, CNT_W=4): 17 transfers from requester 0 → `grant_cnt[0]=1` (wrapped), other counters 0. Non-stats build passes all scenarios above unchanged.

Source files
------------

// File: rtl/pb_write_arb_pkg.sv
// Shared types for the pixel-buffer write path: the buffer entry and requester indices.
package pb_write_arb_pkg;

  typedef struct packed {
    logic [15:0] pixel_id;
    logic [23:0] color;
  } pixel_buffer_entry_t;

  localparam int PB_REQ_SHADER = 0;
  localparam int PB_REQ_MISS   = 1;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ff_ar.sv
// Plain D flop bank with asynchronous active-low reset to a parameterised value.
module ff_ar #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State register; reset value is applied asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after `last`, scanning upward with wrap.
module rr_pick
  import pb_write_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   idx;
  logic found;

  // Scan offsets 1..N so `last` itself has the lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/pb_write_arb.sv
// Round-robin arbiter and output register for the shared pixel-buffer write port.
// Define PB_ARB_STATS_EN to build the per-requester grant counters and the grant_cnt port.
module pb_write_arb
  import pb_write_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  pixel_buffer_entry_t [NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]                 req_stall,
  input  logic                               pb_full,
  output pixel_buffer_entry_t                pb_data,
  output logic                               pb_we,
  output logic                               arb_idle
`ifdef PB_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0]      grant_cnt
`endif
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int DW = $bits(pixel_buffer_entry_t);

  logic                out_valid;
  logic                out_valid_d;
  pixel_buffer_entry_t out_data;
  pixel_buffer_entry_t out_data_d;
  logic [IW-1:0]       last;
  logic [IW-1:0]       last_d;
  logic [IW-1:0]       grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                load;
  logic                any_req;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req       (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Next-state of the output register and the per-requester stalls.
  always_comb begin
    load        = !out_valid || !pb_full;
    any_req     = |req_valid;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    last_d      = last;
    if (load) begin
      out_valid_d = any_req;
      if (any_req) begin
        out_data_d = req_data[grant_idx];
        last_d     = grant_idx;
      end else begin
        out_data_d = out_data;
      end
    end else begin
      out_valid_d = out_valid;
    end
    // rst gates the stalls so nothing is accepted while reset is held.
    req_stall = ~(grant & {NUM_REQ{load && rst}});
  end

  ff_ar #(.W(1)) u_out_valid (.clk(clk), .rst(rst), .d(out_valid_d), .q(out_valid));
  ff_ar #(.W(DW)) u_out_data (.clk(clk), .rst(rst), .d(out_data_d), .q(out_data));
  ff_ar #(.W(IW), .RST_VAL(IW'(NUM_REQ - 1))) u_last (.clk(clk), .rst(rst), .d(last_d), .q(last));

  assign pb_we    = out_valid && !pb_full;
  assign pb_data  = out_data;
  assign arb_idle = !out_valid && !any_req;

`ifdef PB_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_d;
    assign cnt_d = grant_cnt[i] + {{(CNT_W - 1){1'b0}}, (load && grant[i])};
    ff_ar #(.W(CNT_W)) u_cnt (.clk(clk), .rst(rst), .d(cnt_d), .q(grant_cnt[i]));
  end
`else
`endif

endmodule

// File: tb/tb_pb_write_arb.sv
// Directed bench for pb_write_arb: requester queues feed the DUT, a scoreboard holds expected writes.
module tb_pb_write_arb;
  import pb_write_arb_pkg::*;

  localparam int NUM_REQ = 3;
`ifdef PB_ARB_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic                              clk = 1'b0;
  logic                              rst = 1'b0;
  logic [NUM_REQ-1:0]                req_valid = '0;
  pixel_buffer_entry_t [NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]                req_stall;
  logic                              pb_full = 1'b0;
  pixel_buffer_entry_t               pb_data;
  logic                              pb_we;
  logic                              arb_idle;
`ifdef PB_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0]     grant_cnt;
`endif

  pb_write_arb #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_stall (req_stall),
    .pb_full   (pb_full),
    .pb_data   (pb_data),
    .pb_we     (pb_we),
    .arb_idle  (arb_idle)
`ifdef PB_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pixel_buffer_entry_t src[NUM_REQ][$];
  pixel_buffer_entry_t sb[$];
  int                  wlog[$];
  logic                ov_m;
  int                  last_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pixel_buffer_entry_t mk(input int r, input int s);
    pixel_buffer_entry_t e;
    e.pixel_id = {4'(r), 12'(s)};
    e.color    = 24'(s * 37 + r * 1000 + 5);
    return e;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (src[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (src[i].size() != 0);
      req_data[i]  = (src[i].size() != 0) ? src[i][0] : '0;
    end
  endtask

  // One clock of the reference model: check outputs at negedge, then advance.
  task automatic cyc();
    logic                load_m;
    logic                any_m;
    int                  g;
    logic [NUM_REQ-1:0]  exp_stall;
    pixel_buffer_entry_t tmp;
    @(negedge clk);
    load_m    = !ov_m || !pb_full;
    any_m     = |req_valid;
    g         = -1;
    exp_stall = '1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (g < 0 && req_valid[(last_m + k) % NUM_REQ]) g = (last_m + k) % NUM_REQ;
    end
    if (load_m && any_m) exp_stall[g] = 1'b0;
    chk("pb_we", 64'(pb_we), 64'(ov_m && !pb_full));
    chk("req_stall", 64'(req_stall), 64'(exp_stall));
    chk("arb_idle", 64'(arb_idle), 64'(!ov_m && !any_m));
    if (ov_m && sb.size() != 0) chk("pb_data", 64'(pb_data), 64'(sb[0]));
    if (ov_m && !pb_full && sb.size() != 0) begin
      tmp = sb.pop_front();
      wlog.push_back(int'(tmp.pixel_id[15:12]));
    end
    if (load_m) begin
      if (any_m) begin
        tmp = src[g].pop_front();
        sb.push_back(tmp);
        last_m = g;
        ov_m   = 1'b1;
      end else begin
        ov_m = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((pending() || sb.size() != 0) && n < bound) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 64'(n < bound), 64'(1));
  endtask

  // Asserts reset for n cycles; the first check happens before sources are flushed.
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    chk("rst_we", 64'(pb_we), 64'(0));
    chk("rst_stall", 64'(req_stall), 64'({NUM_REQ{1'b1}}));
    for (int i = 0; i < NUM_REQ; i++) src[i].delete();
    sb.delete();
    ov_m   = 1'b0;
    last_m = NUM_REQ - 1;
    drive();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("rst_we", 64'(pb_we), 64'(0));
      chk("rst_stall", 64'(req_stall), 64'({NUM_REQ{1'b1}}));
      chk("rst_idle", 64'(arb_idle), 64'(1));
      chk("rst_data", 64'(pb_data), 64'(0));
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  initial begin
    int exp_ord[9];
    exp_ord = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

    // Reset then idle.
    do_reset(3);
    cyc();
    cyc();

    // Single requester streaming from the scene-miss port.
    wlog.delete();
    for (int s = 0; s < 10; s++) src[PB_REQ_MISS].push_back(mk(PB_REQ_MISS, s));
    drive();
    drain(40);
    chk("stream_count", 64'(wlog.size()), 64'(10));

    // Full contention from a fresh reset: strict 0,1,2 rotation.
    do_reset(1);
    wlog.delete();
    for (int s = 0; s < 3; s++) for (int r = 0; r < NUM_REQ; r++) src[r].push_back(mk(r, 16 + s));
    drive();
    drain(40);
    chk("contend_count", 64'(wlog.size()), 64'(9));
    for (int i = 0; i < 9 && i < wlog.size(); i++) chk("contend_order", 64'(wlog[i]), 64'(exp_ord[i]));

    // Backpressure with a held entry, then release.
    for (int s = 0; s < 2; s++) for (int r = 0; r < NUM_REQ; r++) src[r].push_back(mk(r, 32 + s));
    drive();
    cyc();
    cyc();
    pb_full = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    pb_full = 1'b0;
    drain(40);

    // Simultaneous write and load: last=0, requesters 0 and 2 valid.
    do_reset(1);
    src[PB_REQ_SHADER].push_back(mk(0, 48));
    drive();
    cyc();
    src[PB_REQ_SHADER].push_back(mk(0, 49));
    src[2].push_back(mk(2, 50));
    drive();
    #1;
    chk("simul_stall", 64'(req_stall), 64'(3'b011));
    chk("simul_we", 64'(pb_we), 64'(1));
    drain(20);

`ifdef PB_ARB_STATS_EN
    do_reset(1);
    for (int s = 0; s < 17; s++) src[PB_REQ_SHADER].push_back(mk(0, s));
    drive();
    drain(60);
    cyc();
    chk("cnt0_wrap", 64'(grant_cnt[0]), 64'(1));
    chk("cnt1", 64'(grant_cnt[1]), 64'(0));
    chk("cnt2", 64'(grant_cnt[2]), 64'(0));
`endif

    // Reset mid-operation drops the held entry without a write.
    src[1].push_back(mk(1, 60));
    src[2].push_back(mk(2, 61));
    drive();
    cyc();
    do_reset(2);
    cyc();
    chk("post_rst_idle", 64'(arb_idle), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
